parking_count_sequencer: RTL and testbench

//  Occupancy counter controller for the parking lot. Entry and exit gates request
//  +1/-1 updates, and the block arbitrates between them. Each update runs bit-serially,
//  LSB first, through a single full_adder cell: WIDTH cycles per update, one adder total.

---
 rtl/parking_count_sequencer_pkg.sv | 22 ++
 rtl/parking_count_sequencer_if.sv | 26 ++
 rtl/serial_add_step.sv | 31 +++
 rtl/parking_count_sequencer.sv | 133 +++++++++++++
 tb/tb_parking_count_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/parking_count_sequencer_pkg.sv
// Shared encodings and the full-adder cell function for the parking occupancy
// counter.
package parking_count_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADD  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic OP_ENTER = 1'b0;
  localparam logic OP_EXIT  = 1'b1;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

  // An exit adds all-ones (-1); an enter adds +1, so only bit 0 is set.
  function automatic logic operand_bit(input logic op, input logic first_bit);
    return (op == OP_EXIT) ? 1'b1 : first_bit;
  endfunction

endpackage

// File: rtl/parking_count_sequencer_if.sv
// Gate-side request/acknowledge handshake plus occupancy status for the
// parking counter.
interface parking_count_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enter_req;
  logic             exit_req;
  logic             enter_ack;
  logic             exit_ack;
  logic             enter_deny;
  logic             exit_deny;
  logic [WIDTH-1:0] count;
  logic             full;
  logic             empty;
  logic             busy;

  modport master (
    output enter_req, exit_req,
    input  enter_ack, exit_ack, enter_deny, exit_deny, count, full, empty, busy
  );

  modport slave (
    input  enter_req, exit_req,
    output enter_ack, exit_ack, enter_deny, exit_deny, count, full, empty, busy
  );
endinterface

// File: rtl/serial_add_step.sv
// One bit-serial addition step: full-adder cell plus its carry flop.
// clear zeroes the carry; en lets the carry follow the cell's carry-out.
module serial_add_step
  import parking_count_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic sum_bit
);
  logic carry_q, carry_d;
  logic cout;

  always_comb begin
    {cout, sum_bit} = full_adder(a_bit, b_bit, carry_q);
  end

  always_comb begin
    carry_d = carry_q;
    if (clear)   carry_d = 1'b0;
    else if (en) carry_d = cout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) carry_q <= 1'b0;
    else          carry_q <= carry_d;
  end
endmodule

// File: rtl/parking_count_sequencer.sv
// Parking-lot occupancy counter: arbitrates entry/exit gate requests and
// applies each +1/-1 update bit-serially through one shared adder cell.
module parking_count_sequencer
  import parking_count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CAPACITY = 200
) (
  input  logic                      clk,
  input  logic                      reset_n,
  parking_count_sequencer_if.slave  bus
);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] CAP  = WIDTH'(CAPACITY);
  localparam logic [IW-1:0]    LAST = IW'(WIDTH - 1);

  if (CAPACITY < 1 || 64'(CAPACITY) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_capacity
    $error("parking_count_sequencer: CAPACITY out of range for WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic             op_q, op_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             full, empty;
  logic             elig_enter, elig_exit;
  logic             add_clear, add_en, sum_bit;
  logic             enter_ack, exit_ack, enter_deny, exit_deny;
  logic [WIDTH:0]   shifted;

  assign full       = (count_q == CAP);
  assign empty      = (count_q == '0);
  assign elig_enter = bus.enter_req & ~full;
  assign elig_exit  = bus.exit_req  & ~empty;
  assign shifted    = {sum_bit, shift_q};

  serial_add_step u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (add_clear),
    .en      (add_en),
    .a_bit   (shift_q[0]),
    .b_bit   (operand_bit(op_q, idx_q == '0)),
    .sum_bit (sum_bit)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ptr_d      = ptr_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    count_d    = count_q;
    add_clear  = 1'b0;
    add_en     = 1'b0;
    enter_ack  = 1'b0;
    exit_ack   = 1'b0;
    enter_deny = 1'b0;
    exit_deny  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (elig_enter || elig_exit) begin
          // Pointer only moves on contested grants; a lone requester leaves it alone.
          if (elig_enter && elig_exit) begin
            op_d  = ptr_q;
            ptr_d = (ptr_q == OP_ENTER) ? OP_EXIT : OP_ENTER;
          end else begin
            op_d = elig_exit ? OP_EXIT : OP_ENTER;
          end
          shift_d   = count_q;
          idx_d     = '0;
          add_clear = 1'b1;
          state_d   = ST_ADD;
        end else if (bus.enter_req) begin
          enter_ack  = 1'b1;
          enter_deny = 1'b1;
        end else if (bus.exit_req) begin
          exit_ack  = 1'b1;
          exit_deny = 1'b1;
        end
      end

      ST_ADD: begin
        add_en  = 1'b1;
        shift_d = shifted[WIDTH:1];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          count_d = shifted[WIDTH:1];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        enter_ack = (op_q == OP_ENTER);
        exit_ack  = (op_q == OP_EXIT);
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ENTER;
      ptr_q   <= OP_ENTER;
      shift_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign bus.enter_ack  = enter_ack;
  assign bus.exit_ack   = exit_ack;
  assign bus.enter_deny = enter_deny;
  assign bus.exit_deny  = exit_deny;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.busy       = (state_q == ST_ADD) || (state_q == ST_DONE);
endmodule

// File: tb/tb_parking_count_sequencer.sv
// Directed scoreboard bench for parking_count_sequencer across three
// width/capacity configurations.
module tb_parking_count_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  parking_count_sequencer_if #(.WIDTH(8)) if0 ();
  parking_count_sequencer_if #(.WIDTH(8)) if1 ();
  parking_count_sequencer_if #(.WIDTH(4)) if2 ();

  parking_count_sequencer #(.WIDTH(8), .CAPACITY(200)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  parking_count_sequencer #(.WIDTH(8), .CAPACITY(3))   u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  parking_count_sequencer #(.WIDTH(4), .CAPACITY(15))  u2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  typedef struct {
    bit is_exit;
    bit deny;
    int cnt;
    int lat;
  } exp_t;

  typedef struct {
    bit ae, ax, de, dx, full, empty, busy;
    int cnt;
  } obs_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cap [3] = '{200, 3, 15};
  int   wid [3] = '{8, 8, 4};

  function automatic obs_t sample(input int inst);
    obs_t s;
    case (inst)
      0: begin
        s.ae = if0.enter_ack; s.ax = if0.exit_ack; s.de = if0.enter_deny; s.dx = if0.exit_deny;
        s.full = if0.full; s.empty = if0.empty; s.busy = if0.busy; s.cnt = int'(if0.count);
      end
      1: begin
        s.ae = if1.enter_ack; s.ax = if1.exit_ack; s.de = if1.enter_deny; s.dx = if1.exit_deny;
        s.full = if1.full; s.empty = if1.empty; s.busy = if1.busy; s.cnt = int'(if1.count);
      end
      default: begin
        s.ae = if2.enter_ack; s.ax = if2.exit_ack; s.de = if2.enter_deny; s.dx = if2.exit_deny;
        s.full = if2.full; s.empty = if2.empty; s.busy = if2.busy; s.cnt = int'(if2.count);
      end
    endcase
    return s;
  endfunction

  task automatic set_req(input int inst, input bit is_exit, input bit v);
    case (inst)
      0:       if (is_exit) if0.exit_req = v; else if0.enter_req = v;
      1:       if (is_exit) if1.exit_req = v; else if1.enter_req = v;
      default: if (is_exit) if2.exit_req = v; else if2.enter_req = v;
    endcase
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next ack on one instance and checks it against the queue head.
  task automatic wait_ack(input int inst, input string tag, inout int c);
    exp_t e;
    obs_t s;
    bit   got = 1'b0;
    int   lim = 4 * wid[inst] + 20;
    if (sb.size() == 0) begin
      $display("FAIL %s.scoreboard: observed empty queue, expected an entry", tag);
      n_err++;
      return;
    end
    e = sb.pop_front();
    while (!got && c < lim) begin
      @(negedge clk);
      s = sample(inst);
      if (e.lat >= 0) check({tag, ".busy"}, int'(s.busy), (e.deny || c == 0) ? 0 : 1);
      if (s.ae || s.ax) begin
        got = 1'b1;
        check({tag, ".kind"},  int'(s.ax), int'(e.is_exit));
        check({tag, ".deny"},  int'(s.ax ? s.dx : s.de), int'(e.deny));
        check({tag, ".count"}, s.cnt, e.cnt);
        check({tag, ".full"},  int'(s.full),  (e.cnt == cap[inst]) ? 1 : 0);
        check({tag, ".empty"}, int'(s.empty), (e.cnt == 0) ? 1 : 0);
        if (e.lat >= 0) check({tag, ".latency"}, c, e.lat);
      end
      c++;
    end
    check({tag, ".ack_seen"}, int'(got), 1);
    @(posedge clk);
    #1;
    if (got) set_req(inst, s.ax, 1'b0);
  endtask

  task automatic request(input int inst, input bit is_exit, input bit deny, input int cnt, input string tag);
    int c = 0;
    sb.push_back('{is_exit: is_exit, deny: deny, cnt: cnt, lat: deny ? 0 : wid[inst] + 1});
    @(posedge clk);
    #1;
    set_req(inst, is_exit, 1'b1);
    wait_ack(inst, tag, c);
  endtask

  task automatic pair(input int inst, input bit first_exit, input int cnt_mid, input int cnt_end, input string tag);
    int c = 0;
    sb.push_back('{is_exit: first_exit,  deny: 1'b0, cnt: cnt_mid, lat: wid[inst] + 1});
    sb.push_back('{is_exit: !first_exit, deny: 1'b0, cnt: cnt_end, lat: -1});
    @(posedge clk);
    #1;
    set_req(inst, 1'b0, 1'b1);
    set_req(inst, 1'b1, 1'b1);
    wait_ack(inst, {tag, ".first"}, c);
    wait_ack(inst, {tag, ".second"}, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t s;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, 1'b0);
      set_req(k, 1'b1, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      s = sample(k);
      check($sformatf("reset%0d.count", k), s.cnt, 0);
      check($sformatf("reset%0d.empty", k), int'(s.empty), 1);
      check($sformatf("reset%0d.full", k),  int'(s.full), 0);
      check($sformatf("reset%0d.busy", k),  int'(s.busy), 0);
      check($sformatf("reset%0d.acks", k),  int'({s.ae, s.ax, s.de, s.dx}), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Single enter, then build up to 5.
    request(0, 1'b0, 1'b0, 1, "t1.enter");
    for (int i = 2; i <= 5; i++) request(0, 1'b0, 1'b0, i, $sformatf("t1.fill%0d", i));

    // Contested pairs: ENTER wins first, EXIT wins the next contest.
    pair(0, 1'b0, 6, 5, "t2.pair1");
    pair(0, 1'b1, 4, 5, "t2.pair2");

    // Empty lot exit is denied; small lot fills then denies.
    request(1, 1'b1, 1'b1, 0, "t4.exit_empty");
    for (int i = 1; i <= 3; i++) request(1, 1'b0, 1'b0, i, $sformatf("t3.fill%0d", i));
    request(1, 1'b0, 1'b1, 3, "t3.enter_full");

    // Narrow counter: carry ripple and all-ones operand.
    for (int i = 1; i <= 7; i++) request(2, 1'b0, 1'b0, i, $sformatf("t5.fill%0d", i));
    request(2, 1'b0, 1'b0, 8, "t5.enter7to8");
    request(2, 1'b1, 1'b0, 7, "t5.exit8to7");
    for (int i = 8; i <= 15; i++) request(2, 1'b0, 1'b0, i, $sformatf("t5.top%0d", i));
    request(2, 1'b1, 1'b0, 14, "t5.exit15to14");
    request(2, 1'b0, 1'b0, 15, "t5.refill");
    request(2, 1'b0, 1'b1, 15, "t5.enter_full");

    // Reset in the middle of an enter from count 4.
    request(0, 1'b1, 1'b0, 4, "t6.prep");
    @(posedge clk);
    #1;
    if0.enter_req = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    s = sample(0);
    check("t6.abort_count", s.cnt, 0);
    check("t6.abort_busy",  int'(s.busy), 0);
    if0.enter_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s = sample(0);
      check($sformatf("t6.no_ack%0d", i), int'(s.ae), 0);
    end
    request(0, 1'b0, 1'b0, 1, "t6.fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
